// File: rtl/chase_ctrl.sv
// chase_ctrl: single-segment chase around the outer ring of a 3-digit
// 7-segment display, with a time-multiplexed digit scan.
module chase_digit #(
  parameter int IDX = 0
) (
  input  logic       lit,
  input  logic [1:0] dg,
  input  logic [2:0] sg,
  output logic [6:0] seg
);
  // one digit's active-low pattern: light segment sg only if this digit owns pos
  always_comb begin
    seg = 7'h7F;
    if (lit && dg == 2'(IDX)) seg = ~(7'b0000001 << sg);
  end
endmodule

module chase_ctrl #(
  parameter int REFRESH_DIV = 50000,
  parameter int STEP_DIV    = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       dir,
  input  logic       mode,
  output logic [1:0] select,
  output logic [2:0] an,
  output logic [6:0] seg0,
  output logic [6:0] seg1,
  output logic [6:0] seg2,
  output logic [3:0] pos,
  output logic       step
);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam int SW = $clog2(STEP_DIV);
  localparam logic [RW-1:0] R_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] S_LAST = SW'(STEP_DIV - 1);

  typedef enum logic {FWD = 1'b0, REV = 1'b1} dir_t;

  logic [RW-1:0] rcnt;
  logic [SW-1:0] scnt;
  logic [1:0]    sel_nxt;
  logic [3:0]    pos_nxt;
  logic          fire;
  dir_t          st, st_nxt;

  assign sel_nxt = (select == 2'd2) ? 2'd0 : select + 2'd1;
  assign fire    = en && (scnt == S_LAST);

  // digit-scan refresh: free-running slot counter advancing select/an
  always_ff @(posedge clk) begin
    if (reset) begin
      rcnt   <= '0;
      select <= 2'd0;
      an     <= 3'b110;
    end else if (rcnt == R_LAST) begin
      rcnt   <= '0;
      select <= sel_nxt;
      an     <= ~(3'b001 << sel_nxt);
    end else begin
      rcnt   <= rcnt + 1'b1;
    end
  end

  // next ring position for the current direction; out-of-range values recover
  always_comb begin
    pos_nxt = pos;
    if (st == FWD) pos_nxt = (pos >= 4'd9) ? 4'd0 : pos + 4'd1;
    else           pos_nxt = (pos == 4'd0 || pos > 4'd9) ? 4'd9 : pos - 4'd1;
  end

  // direction state register
  always_ff @(posedge clk) begin
    if (reset) st <= FWD;
    else       st <= st_nxt;
  end

  // direction next-state: follow dir in wrap mode, turn at the ends in bounce mode
  always_comb begin
    st_nxt = st;
    if (!mode) begin
      st_nxt = dir ? REV : FWD;
    end else if (fire) begin
      if (st == FWD && pos_nxt == 4'd9)      st_nxt = REV;
      else if (st == REV && pos_nxt == 4'd0) st_nxt = FWD;
    end
  end

  // step divider, position register and one-cycle step pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      scnt <= '0;
      pos  <= 4'd0;
      step <= 1'b0;
    end else begin
      step <= fire;
      if (en) scnt <= fire ? '0 : scnt + 1'b1;
      if (fire) pos <= pos_nxt;
    end
  end

  // ring position -> owning digit and segment index (a=0 .. f=5)
  logic       lit;
  logic [1:0] dg;
  logic [2:0] sg;
  always_comb begin
    lit = 1'b1;
    dg  = 2'd0;
    sg  = 3'd0;
    case (pos)
      4'd0: begin dg = 2'd2; sg = 3'd0; end
      4'd1: begin dg = 2'd1; sg = 3'd0; end
      4'd2: begin dg = 2'd0; sg = 3'd0; end
      4'd3: begin dg = 2'd0; sg = 3'd1; end
      4'd4: begin dg = 2'd0; sg = 3'd2; end
      4'd5: begin dg = 2'd0; sg = 3'd3; end
      4'd6: begin dg = 2'd1; sg = 3'd3; end
      4'd7: begin dg = 2'd2; sg = 3'd3; end
      4'd8: begin dg = 2'd2; sg = 3'd4; end
      4'd9: begin dg = 2'd2; sg = 3'd5; end
      default: lit = 1'b0;
    endcase
  end

  logic [2:0][6:0] segs;
  for (genvar k = 0; k < 3; k++) begin : g_dig
    chase_digit #(.IDX(k)) u_dig (.lit(lit), .dg(dg), .sg(sg), .seg(segs[k]));
  end

  assign seg0 = segs[0];
  assign seg1 = segs[1];
  assign seg2 = segs[2];
endmodule

// File: tb/tb_chase_ctrl.sv
// tb_chase_ctrl: directed scoreboard bench for chase_ctrl (REFRESH_DIV=4, STEP_DIV=8)
module tb_chase_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0, dir = 1'b0, mode = 1'b0;
  logic [1:0] select;
  logic [2:0] an;
  logic [6:0] seg0, seg1, seg2;
  logic [3:0] pos;
  logic       step;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int q[$];
  bit tog = 1'b0;

  chase_ctrl #(.REFRESH_DIV(4), .STEP_DIV(8)) dut (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .mode(mode),
    .select(select), .an(an), .seg0(seg0), .seg1(seg1), .seg2(seg2),
    .pos(pos), .step(step)
  );

  // free-running clock
  always #5 clk = ~clk;

  // expected {seg2,seg1,seg0} for each ring position
  function automatic logic [20:0] exp_segs(int p);
    case (p)
      0: return {7'b1111110, 7'h7F, 7'h7F};
      1: return {7'h7F, 7'b1111110, 7'h7F};
      2: return {7'h7F, 7'h7F, 7'b1111110};
      3: return {7'h7F, 7'h7F, 7'b1111101};
      4: return {7'h7F, 7'h7F, 7'b1111011};
      5: return {7'h7F, 7'h7F, 7'b1110111};
      6: return {7'h7F, 7'b1110111, 7'h7F};
      7: return {7'b1110111, 7'h7F, 7'h7F};
      8: return {7'b1101111, 7'h7F, 7'h7F};
      9: return {7'b1011111, 7'h7F, 7'h7F};
      default: return {3{7'h7F}};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // hold reset two edges, then release with the given inputs
  task automatic do_reset(input logic e, input logic d, input logic m);
    reset = 1'b1;
    tick(2);
    en = e; dir = d; mode = m;
    reset = 1'b0;
    q.delete();
  endtask

  // wait for the next step pulse, bounded; returns negedges waited
  task automatic wait_step(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (tog) dir = ~dir;
    end while (!step && n < 40);
  endtask

  // pop the next expected position and compare once the DUT steps
  task automatic do_step(input string tag, input int gap);
    int n, e;
    wait_step(n);
    chk({tag, " gap"}, n, gap);
    e = q.pop_front();
    chk({tag, " pos"}, pos, e);
    chk({tag, " seg"}, {seg2, seg1, seg0}, exp_segs(e));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " sel"}, select, 0);
    chk({tag, " an"}, an, 3'b110);
    chk({tag, " pos"}, pos, 0);
    chk({tag, " step"}, step, 0);
    chk({tag, " seg"}, {seg2, seg1, seg0}, {7'b1111110, 7'h7F, 7'h7F});
  endtask

  initial begin
    int n;
    // reset state and digit scan with en low
    tick(2);
    chk_reset_vals("rst");
    do_reset(1'b0, 1'b0, 1'b0);
    tick(1);  chk("scan1 sel", select, 0); chk("scan1 an", an, 3'b110);
    tick(2);  chk("scan3 sel", select, 0);
    tick(1);  chk("scan4 sel", select, 1); chk("scan4 an", an, 3'b101);
    tick(4);  chk("scan8 sel", select, 2); chk("scan8 an", an, 3'b011);
    tick(4);  chk("scan12 sel", select, 0); chk("scan12 an", an, 3'b110);
    chk("idle pos", pos, 0);

    // wrap forward
    do_reset(1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) q.push_back(i % 10);
    for (int i = 0; i < 10; i++) do_step("fwd", 8);

    // wrap reverse from reset
    do_reset(1'b1, 1'b1, 1'b0);
    q.push_back(9); q.push_back(8);
    do_step("rev", 8); do_step("rev", 8);

    // bounce with dir toggling
    do_reset(1'b1, 1'b0, 1'b1);
    tog = 1'b1;
    for (int i = 1; i <= 9; i++) q.push_back(i);
    for (int i = 8; i >= 0; i--) q.push_back(i);
    q.push_back(1); q.push_back(2);
    for (int i = 0; i < 20; i++) do_step("bnc", 8);
    tog = 1'b0;

    // switch to bounce at 9 in FWD: wraps outward to 0, then back to wrap/REV
    do_reset(1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 9; i++) q.push_back(i);
    for (int i = 0; i < 9; i++) do_step("pre", 8);
    mode = 1'b1; dir = 1'b1;
    q.push_back(0); q.push_back(1);
    do_step("out", 8); do_step("out", 8);
    mode = 1'b0;
    q.push_back(0); q.push_back(9);
    do_step("back", 8); do_step("back", 8);

    // en pause holds the step counter
    do_reset(1'b1, 1'b0, 1'b0);
    tick(5);
    en = 1'b0;
    tick(20);
    chk("hold pos", pos, 0);
    en = 1'b1;
    q.push_back(1);
    do_step("resume", 3);

    // reset mid-step (counter 6, pos 5, REV)
    do_reset(1'b1, 1'b1, 1'b0);
    for (int i = 9; i >= 5; i--) q.push_back(i);
    for (int i = 0; i < 5; i++) do_step("pre2", 8);
    tick(6);
    reset = 1'b1;
    tick(1);
    chk_reset_vals("midrst");
    tick(1);
    en = 1'b1; dir = 1'b1; mode = 1'b1;
    reset = 1'b0;
    q.delete();
    q.push_back(1);
    do_step("postrst", 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
